// File: rtl/fprint_scratchpad_arbiter.sv
// fprint_scratchpad_arbiter
//   Two-master arbiter in front of a single-port scratchpad RAM.
//   Master 0 is the processor data port. Master 1 is the fingerprint/DMA port.
//   Each master gets a combinational grant in its request cycle, with
//   round-robin between the two masters when both request.
//   Read data comes back one cycle after the address cycle. It is steered
//   to the right master by a one-bit read-return tag.
//
// Optional feature (macro FPRINT_SP_LOCK_EN):
//   When defined, master 1 keeps winning conflicts while m1_lock is high,
//   provided master 1 received the most recent grant.
//   When undefined, m1_lock is ignored.
//
// Ports
//   clk, reset_n            clock and asynchronous active-low reset
//   m0_* / m1_*             Avalon-style master ports:
//                           address, read, write, byteenable, writedata,
//                           waitrequest, readdata, readdatavalid
//   m1_lock                 master 1 exclusive-hold request
//   sp_*                    scratchpad port:
//                           address, byteenable, writedata, chipselect,
//                           write, readdata
//   conflict_count          saturating count of cycles in which both
//                           masters requested

module fprint_scratchpad_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    input  logic                m1_lock,

    output logic [ADDR_W-1:0]   sp_address,
    output logic [DATA_W/8-1:0] sp_byteenable,
    output logic [DATA_W-1:0]   sp_writedata,
    output logic                sp_chipselect,
    output logic                sp_write,
    input  logic [DATA_W-1:0]   sp_readdata,

    output logic [15:0]         conflict_count
);

    logic m0_req;
    logic m1_req;
    logic grant_m0;
    logic grant_m1;
    logic grant_is_read;
    logic lock_hold;
    logic m1_wins_conflict;
    logic last_grant;     // 1: master 1 was granted most recently
    logic rd_valid;
    logic rd_id;          // master that owns the read data now on sp_readdata

`ifdef FPRINT_SP_LOCK_EN
    assign lock_hold = last_grant & m1_lock;
`else
    logic unused_m1_lock;
    assign unused_m1_lock = m1_lock;
    assign lock_hold      = 1'b0;
`endif

    assign m0_req           = m0_read | m0_write;
    assign m1_req           = m1_read | m1_write;
    assign m1_wins_conflict = ~last_grant | lock_hold;

    // Grants are gated by reset_n so nothing reaches the RAM while reset is held.
    assign grant_m1 = reset_n & m1_req & (~m0_req | m1_wins_conflict);
    assign grant_m0 = reset_n & m0_req & ~grant_m1;

    // If a master asserts read and write together, the transfer is a write.
    always_comb begin
        grant_is_read = 1'b0;
        if (grant_m1) begin
            grant_is_read = m1_read & ~m1_write;
        end else if (grant_m0) begin
            grant_is_read = m0_read & ~m0_write;
        end
    end

    // Master 0 drives the scratchpad bus whenever master 1 is not granted.
    // With no grant the bus is idle, because chipselect stays low.
    assign sp_address     = grant_m1 ? m1_address    : m0_address;
    assign sp_byteenable  = grant_m1 ? m1_byteenable : m0_byteenable;
    assign sp_writedata   = grant_m1 ? m1_writedata  : m0_writedata;
    assign sp_chipselect  = grant_m0 | grant_m1;
    assign sp_write       = grant_m1 ? m1_write : (grant_m0 & m0_write);

    assign m0_waitrequest = m0_req & ~grant_m0;
    assign m1_waitrequest = m1_req & ~grant_m1;

    assign m0_readdata      = sp_readdata;
    assign m1_readdata      = sp_readdata;
    assign m0_readdatavalid = rd_valid & ~rd_id;
    assign m1_readdatavalid = rd_valid &  rd_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= 1'b1;
            rd_valid       <= 1'b0;
            rd_id          <= 1'b0;
            conflict_count <= 16'd0;
        end else begin
            if (grant_m0 | grant_m1) begin
                last_grant <= grant_m1;
            end
            rd_valid <= grant_is_read;
            rd_id    <= grant_m1;
            if (m0_req && m1_req && conflict_count != 16'hFFFF) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fprint_scratchpad_arbiter.sv
module tb_fprint_scratchpad_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write, m1_lock;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [11:0] sp_address;
    logic [3:0]  sp_byteenable;
    logic [31:0] sp_writedata;
    logic        sp_chipselect, sp_write;
    logic [31:0] sp_readdata;
    logic [15:0] conflict_count;

    int checks = 0;
    int errors = 0;
    int rdv_pulses;

`ifdef FPRINT_SP_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    fprint_scratchpad_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_lock(m1_lock),
        .sp_address(sp_address), .sp_byteenable(sp_byteenable),
        .sp_writedata(sp_writedata), .sp_chipselect(sp_chipselect),
        .sp_write(sp_write), .sp_readdata(sp_readdata),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    // Scratchpad model: read data is a tag plus the address, one cycle after the address cycle.
    function automatic logic [31:0] mem_val(input logic [11:0] a);
        return 32'hA500_0000 | {20'd0, a};
    endfunction

    always @(posedge clk) begin
        if (sp_chipselect && !sp_write) sp_readdata <= mem_val(sp_address);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        m0_address = '0; m1_address = '0;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; m1_lock = 0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;
        sp_readdata = '0;

        // While reset is held, both masters request and neither is granted.
        m0_read = 1; m1_read = 1;
        tick();
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_cs", sp_chipselect, 0);
        chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        chk("rst_cnt", conflict_count, 0);
        m0_read = 0; m1_read = 0;
        tick();
        reset_n = 1'b1;

        // Simultaneous reads after reset: m0 first, then m1.
        tick();
        m0_read = 1; m0_address = 12'h010; m1_read = 1; m1_address = 12'h020;
        #1;
        chk("conf_g0_wait0", m0_waitrequest, 0);
        chk("conf_g0_wait1", m1_waitrequest, 1);
        chk("conf_g0_addr", sp_address, 12'h010);
        chk("conf_g0_cs", {sp_chipselect, sp_write}, 2'b10);
        tick();
        m0_read = 0;
        #1;
        chk("conf_g1_addr", sp_address, 12'h020);
        chk("conf_g1_wait1", m1_waitrequest, 0);
        chk("conf_rdv0", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        chk("conf_rd0", m0_readdata, mem_val(12'h010));
        tick();
        m1_read = 0;
        #1;
        chk("conf_rdv1", {m0_readdatavalid, m1_readdatavalid}, 2'b01);
        chk("conf_rd1", m1_readdata, mem_val(12'h020));
        chk("conf_cnt", conflict_count, 1);
        tick();
        chk("conf_rdv_idle", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

        // m1 write at the top address.
        m1_write = 1; m1_address = 12'hFFF; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
        #1;
        chk("wr_strobes", {sp_chipselect, sp_write}, 2'b11);
        chk("wr_be", sp_byteenable, 4'b0011);
        chk("wr_addr", sp_address, 12'hFFF);
        chk("wr_data", sp_writedata, 32'hDEADBEEF);
        chk("wr_wait1", m1_waitrequest, 0);
        tick();
        m1_write = 0; m1_byteenable = 4'hF;
        #1;
        chk("wr_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

        // m0 asserts read and write together: handled as a write, so no read return.
        tick();
        m0_read = 1; m0_write = 1; m0_address = 12'h055;
        #1;
        chk("rw_write", {sp_chipselect, sp_write}, 2'b11);
        tick();
        m0_read = 0; m0_write = 0;
        #1;
        chk("rw_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

        // Eight cycles of continuous reads from both masters. Grants alternate.
        do_reset();
        m0_read = 1; m0_address = 12'h100; m1_read = 1; m1_address = 12'h200;
        rdv_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_grant0", m0_waitrequest, (i % 2 == 1));
            chk("rr_grant1", m1_waitrequest, (i % 2 == 0));
            if (i > 0) begin
                chk("rr_rdv", {m0_readdatavalid, m1_readdatavalid},
                    ((i - 1) % 2 == 0) ? 2'b10 : 2'b01);
                chk("rr_data", m0_readdata,
                    mem_val(((i - 1) % 2 == 0) ? 12'h100 : 12'h200));
            end
            rdv_pulses += int'(m0_readdatavalid) + int'(m1_readdatavalid);
            if (i == 7) chk("rr_cnt7", conflict_count, 7);
            tick();
        end
        m0_read = 0; m1_read = 0;
        #1;
        chk("rr_last_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b01);
        rdv_pulses += int'(m0_readdatavalid) + int'(m1_readdatavalid);
        chk("rr_pulses", rdv_pulses, 8);
        chk("rr_cnt8", conflict_count, 8);

        // A reset arriving just after a read grant discards the pending return.
        tick();
        m0_read = 1; m0_address = 12'h030;
        #1;
        chk("rstf_grant", m0_waitrequest, 0);
        tick();
        m0_read = 0;
        reset_n = 0;
        #1;
        chk("rstf_rdv_in", m0_readdatavalid, 0);
        tick();
        reset_n = 1;
        #1;
        chk("rstf_rdv_out", m0_readdatavalid, 0);
        chk("rstf_cnt", conflict_count, 0);
        tick();
        chk("rstf_rdv_late", m0_readdatavalid, 0);
        m0_read = 1; m1_read = 1;
        #1;
        chk("rstf_conf_m0", {m0_waitrequest, m1_waitrequest}, 2'b01);
        tick();
        m0_read = 0; m1_read = 0;
        tick();
        tick();

        // m1 holds the scratchpad with m1_lock (only when the lock feature is built in).
        m1_read = 1; m1_lock = 1;
        #1;
        chk("lock_m1_first", m1_waitrequest, 0);
        tick();
        m0_read = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lock_m0_wait", m0_waitrequest, LOCK_ON ? 1'b1 : (k % 2 == 1));
            tick();
        end
        m1_lock = 0;
        #1;
        chk("lock_release", {m0_waitrequest, m1_waitrequest}, 2'b01);
        tick();
        m0_read = 0; m1_read = 0;

        // Saturation of conflict_count.
        do_reset();
        m0_read = 1; m1_read = 1;
        for (int n = 0; n < 65540; n++) begin
            tick();
            if (n == 65533) chk("sat_fffe", conflict_count, 16'hFFFE);
        end
        chk("sat_hold", conflict_count, 16'hFFFF);
        m0_read = 0; m1_read = 0;
        tick();
        chk("sat_idle", conflict_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
